// File: rtl/spi_frame_master_if.sv
// Request, serial-link and reply signals of the SPI frame master.
// The master modport is the DUT side; slave is the upstream/link side.
interface spi_frame_master_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, ss, mosi, rx_data, rx_valid, busy
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, ss, mosi, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_frame_master.sv
// SPI frame master: start bit + DATA_W bits MSB first; first ss low one cycle after accept.
// One-entry holding buffer; tx_ready drops while it is full, so frames run back-to-back.
module spi_frame_master #(
  parameter int DATA_W = 4,
  parameter int GAP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_frame_master_if.master bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              tx_ready_w;
  logic              accept;
  logic              drain;

  // Held low through reset so nothing is offered a handshake it cannot keep.
  assign tx_ready_w = rst_n && !hold_full_q;
  assign accept     = bus.tx_valid && tx_ready_w;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    rsh_d       = rsh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    drain       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          drain   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        bit_cnt_d = CW'(DATA_W - 1);
        state_d   = S_DATA;
      end
      S_DATA: begin
        sh_d      = sh_q << 1;
        rsh_d     = (rsh_q << 1) | DATA_W'(bus.miso);
        bit_cnt_d = bit_cnt_q - CW'(1);
        if (bit_cnt_q == '0) begin
          state_d    = S_GAP;
          gap_cnt_d  = GW'(GAP - 1);
          rx_data_d  = rsh_d;
          rx_valid_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          if (hold_full_q) begin
            drain   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Drain and accept are exclusive: a drain needs the buffer full, which blocks accept.
    if (drain) begin
      sh_d        = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    // ss/mosi are registered, so they follow the state being entered.
    ss_d   = !((state_d == S_START) || (state_d == S_DATA));
    mosi_d = 1'b0;
    if (state_d == S_START) begin
      mosi_d = 1'b1;
    end else if (state_d == S_DATA) begin
      mosi_d = sh_d[DATA_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      rsh_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      rsh_q       <= rsh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
    end
  end

  assign bus.tx_ready = tx_ready_w;
  assign bus.ss       = ss_q;
  assign bus.mosi     = mosi_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: GAP=1 and GAP=3 instances share stimulus and are checked
// every cycle against a frame-offset model, plus literal expectations for directed frames.
module tb_spi_frame_master;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         miso;

  always #5 clk = ~clk;

  spi_frame_master_if #(.DATA_W(W)) bus0 ();
  spi_frame_master_if #(.DATA_W(W)) bus1 ();

  assign bus0.tx_valid = tx_valid;
  assign bus0.tx_data  = tx_data;
  assign bus0.miso     = miso;
  assign bus1.tx_valid = tx_valid;
  assign bus1.tx_data  = tx_data;
  assign bus1.miso     = miso;

  spi_frame_master #(.DATA_W(W), .GAP(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_frame_master #(.DATA_W(W), .GAP(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic         o_ss   [2];
  logic         o_mosi [2];
  logic         o_busy [2];
  logic         o_rdy  [2];
  logic         o_rxv  [2];
  logic [W-1:0] o_rxd  [2];

  assign o_ss[0]   = bus0.ss;       assign o_ss[1]   = bus1.ss;
  assign o_mosi[0] = bus0.mosi;     assign o_mosi[1] = bus1.mosi;
  assign o_busy[0] = bus0.busy;     assign o_busy[1] = bus1.busy;
  assign o_rdy[0]  = bus0.tx_ready; assign o_rdy[1]  = bus1.tx_ready;
  assign o_rxv[0]  = bus0.rx_valid; assign o_rxv[1]  = bus1.rx_valid;
  assign o_rxd[0]  = bus0.rx_data;  assign o_rxd[1]  = bus1.rx_data;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d @%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Model: a frame is a word plus its offset d since the START cycle.
  // d=0 start bit, d=1..W data bits, d=W+1..W+GAP gap cycles.
  int           gapv [2] = '{1, 3};
  bit           m_active [2];
  int           m_d      [2];
  logic [W-1:0] m_w      [2];
  logic [W-1:0] m_buf    [2];
  bit           m_full   [2];
  logic [W-1:0] m_rxw    [2];
  logic [W-1:0] m_rxd    [2];
  bit           m_rxv    [2];
  int           m_old;
  bit           m_acc;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_active[i] = 1'b0;
        m_full[i]   = 1'b0;
        m_d[i]      = 0;
        m_rxd[i]    = '0;
        m_rxv[i]    = 1'b0;
      end else begin
        m_acc    = tx_valid && !m_full[i];
        m_rxv[i] = 1'b0;
        if (m_active[i]) begin
          m_old = m_d[i];
          if (m_old >= 1 && m_old <= W) m_rxw[i] = {m_rxw[i][W-2:0], miso};
          if (m_old == W + gapv[i]) begin
            m_active[i] = 1'b0;
          end else begin
            m_d[i] = m_old + 1;
            if (m_d[i] == W + 1) begin
              m_rxv[i] = 1'b1;
              m_rxd[i] = m_rxw[i];
            end
          end
        end
        if (!m_active[i] && m_full[i]) begin
          m_active[i] = 1'b1;
          m_d[i]      = 0;
          m_w[i]      = m_buf[i];
          m_full[i]   = 1'b0;
        end
        if (m_acc) begin
          m_buf[i]  = tx_data;
          m_full[i] = 1'b1;
        end
      end
    end
  end

  logic e_ss, e_mosi;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        e_ss   = !(m_active[i] && m_d[i] <= W);
        e_mosi = m_active[i] && (m_d[i] == 0 || (m_d[i] <= W && m_w[i][W - m_d[i]]));
        check("ss", i, 32'(o_ss[i]), 32'(e_ss));
        check("mosi", i, 32'(o_mosi[i]), 32'(e_mosi));
        check("busy", i, 32'(o_busy[i]), 32'(m_active[i]));
        check("tx_ready", i, 32'(o_rdy[i]), 32'(rst_n && !m_full[i]));
        check("rx_valid", i, 32'(o_rxv[i]), 32'(m_rxv[i]));
        check("rx_data", i, 32'(o_rxd[i]), 32'(m_rxd[i]));
      end
    end
  end

  // Directed schedules: index e is what is driven for edge k+e; record j is after edge k+j.
  logic         s_valid [32];
  logic [W-1:0] s_data  [32];
  logic         s_miso  [32];
  logic         s_rst   [32];
  logic         r_ss   [2][32];
  logic         r_mosi [2][32];
  logic         r_busy [2][32];
  logic         r_rdy  [2][32];
  logic         r_rxv  [2][32];
  logic [W-1:0] r_rxd  [2][32];

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_sched();
    for (int e = 0; e < 32; e++) begin
      s_valid[e] = 1'b0;
      s_data[e]  = W'($urandom);
      s_miso[e]  = 1'($urandom);
      s_rst[e]   = 1'b1;
    end
  endtask

  task automatic run_sched(input int n);
    rst_n = s_rst[0]; tx_valid = s_valid[0]; tx_data = s_data[0]; miso = s_miso[0];
    for (int j = 0; j < n; j++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        r_ss[i][j]   = o_ss[i];
        r_mosi[i][j] = o_mosi[i];
        r_busy[i][j] = o_busy[i];
        r_rdy[i][j]  = o_rdy[i];
        r_rxv[i][j]  = o_rxv[i];
        r_rxd[i][j]  = o_rxd[i];
      end
      rst_n = s_rst[j+1]; tx_valid = s_valid[j+1]; tx_data = s_data[j+1]; miso = s_miso[j+1];
    end
  endtask

  function automatic logic [31:0] pick(input logic a [32], input int s, input int n);
    logic [31:0] v = '0;
    for (int q = 0; q < n; q++) v = {v[30:0], a[s+q]};
    return v;
  endfunction

  function automatic int ones(input logic a [32], input int s, input int n);
    int c = 0;
    for (int q = 0; q < n; q++) if (a[s+q]) c++;
    return c;
  endfunction

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; miso = 1'b0;
    repeat (2) @(posedge clk);
    step();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ss", i, 32'(o_ss[i]), 1);
      check("rst_mosi", i, 32'(o_mosi[i]), 0);
      check("rst_busy", i, 32'(o_busy[i]), 0);
      check("rst_rx", i, 32'(o_rxd[i]), 0);
      check("rst_ready", i, 32'(o_rdy[i]), 0);
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) check("rel_ready", i, 32'(o_rdy[i]), 1);
    repeat (2) step();

    // Single frame 1010, reply 0,1,1,0.
    clear_sched();
    s_valid[0] = 1'b1; s_data[0] = 4'hA;
    s_miso[3] = 1'b0; s_miso[4] = 1'b1; s_miso[5] = 1'b1; s_miso[6] = 1'b0;
    run_sched(12);
    for (int i = 0; i < 2; i++) begin
      check("single_ss_low", i, ones(r_ss[i], 0, 12), 12 - 5);
      check("single_mosi", i, pick(r_mosi[i], 1, 6), 32'b110100);
      check("single_rxv_cnt", i, ones(r_rxv[i], 0, 12), 1);
      check("single_rxv_pos", i, 32'(r_rxv[i][6]), 1);
      check("single_rxd", i, 32'(r_rxd[i][6]), 32'h6);
    end
    check("single_busy", 0, ones(r_busy[0], 0, 12), 6);
    check("single_busy", 1, ones(r_busy[1], 0, 12), 8);
    repeat (4) step();

    // Back-to-back A then 5, with tx_valid held and data changing while the buffer is full.
    clear_sched();
    s_valid[0] = 1'b1; s_data[0] = 4'hA;
    s_valid[3] = 1'b1; s_data[3] = 4'h5;
    for (int e = 4; e < 8; e++) begin
      s_valid[e] = 1'b1;
      s_data[e]  = 4'h5 ^ W'($urandom_range(1, 15));
    end
    run_sched(20);
    check("b2b_ready", 0, pick(r_rdy[0], 1, 7), 32'b1100001);
    check("b2b_ready", 1, pick(r_rdy[1], 1, 9), 32'b110000001);
    check("b2b_ss_gap", 0, pick(r_ss[0], 5, 3), 32'b010);
    check("b2b_ss_gap", 1, pick(r_ss[1], 5, 5), 32'b01110);
    check("b2b_mosi2", 0, pick(r_mosi[0], 7, 6), 32'b101010);
    check("b2b_mosi2", 1, pick(r_mosi[1], 9, 6), 32'b101010);
    repeat (4) step();

    // Reset during the second data bit, then word 3.
    clear_sched();
    s_valid[0] = 1'b1; s_data[0] = 4'hC;
    s_rst[4] = 1'b0;
    s_valid[7] = 1'b1; s_data[7] = 4'h3;
    run_sched(18);
    for (int i = 0; i < 2; i++) begin
      check("mid_rst_state", i, {28'd0, r_ss[i][4], r_mosi[i][4], r_busy[i][4], r_rxv[i][4]},
            32'b1000);
      check("mid_rst_ready", i, pick(r_rdy[i], 4, 2), 32'b01);
      check("mid_rst_no_rxv", i, ones(r_rxv[i], 0, 8), 0);
      check("post_rst_mosi", i, pick(r_mosi[i], 8, 6), 32'b100110);
      check("post_rst_rxv", i, ones(r_rxv[i], 8, 10), 1);
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = W'($urandom);
      miso     = 1'($urandom);
      rst_n    = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1; tx_valid = 1'b0;
    repeat (16) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
